// File: rtl/rsi_pkg.sv
// Shared definitions for the RSI divider-sharing logic.
//   arb_state_e : arbiter sequencing states (IDLE, ISSUE, WAIT, RESP)
//   DIV_WIDTH   : operand/quotient width used by the RSI divider path
//   RSI_NUM_CH  : default number of RSI channels sharing one divider
//   owner_w()   : width of a channel index for a given channel count
package rsi_pkg;

  localparam int unsigned DIV_WIDTH  = 55;
  localparam int unsigned RSI_NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic int unsigned owner_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rsi_div_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector, one bit per channel
//   ptr   : highest-priority channel index for this pick
//   grant : one-hot grant (all zero when no request)
//   idx   : index of the granted channel (0 when no request)
//   any   : at least one request present
module rr_pick
  import rsi_pkg::*;
#(
  parameter  int unsigned NUM_REQ = RSI_NUM_CH,
  localparam int unsigned IW      = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int unsigned cand;
  logic [IW-1:0] cand_i;

  // Scan channels ptr, ptr+1, ... wrapping at NUM_REQ; first hit wins.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    cand_i = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_i = IW'(cand);
      if (!any && req[cand_i]) begin
        any           = 1'b1;
        grant[cand_i] = 1'b1;
        idx           = cand_i;
      end
    end
  end

endmodule

// File: rtl/rsi_div_arbiter.sv
// rsi_div_arbiter: shares one iterative divider between NUM_REQ RSI channels.
// A round-robin grant captures one channel's operands, issues a single
// div_start, waits for div_done and returns the result to that channel only.
//
// Ports:
//   clk, reset           : clock; synchronous active-high reset
//   req_valid/num/den    : per-channel requests, operands packed at [i*WIDTH +: WIDTH]
//   req_ready            : one-hot, one-cycle grant (operands captured that cycle)
//   rsp_valid            : one-hot, one-cycle result strobe to the owning channel
//   rsp_quotient/overflow: result, valid with rsp_valid
//   div_start            : one-cycle start pulse to the divider
//   div_numerator/denom. : latched operands, stable from div_start to div_done
//   div_quotient/done/ovf: divider result interface
//   busy                 : high in every state except IDLE
//   err_timeout          : sticky watchdog error
//
// Build option DIV_TIMEOUT_EN: watchdog in WAIT. After TIMEOUT_CYCLES without
// div_done the op completes with all-ones quotient and overflow set,
// err_timeout latches, and no further requests are granted until reset.
// Without it, WAIT holds indefinitely and err_timeout is constant 0.
module rsi_div_arbiter
  import rsi_pkg::*;
#(
  parameter int unsigned NUM_REQ        = RSI_NUM_CH,
  parameter int unsigned WIDTH          = DIV_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_num,
  input  logic [NUM_REQ*WIDTH-1:0]   req_den,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic                       rsp_overflow,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_numerator,
  output logic [WIDTH-1:0]           div_denominator,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic                       div_done,
  input  logic                       div_overflow,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int unsigned IW = owner_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("rsi_div_arbiter: parameter out of range");
  end

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      ptr_q, owner_q;
  logic [WIDTH-1:0]   num_q, den_q, quo_q;
  logic               ovf_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               grant_en;
  logic               grant_fire;
  logic               timed_out;
  logic               locked;
  logic [WIDTH-1:0]   sel_num, sel_den;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef DIV_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q;
  logic          err_q;

  // Counter holds the number of WAIT cycles already spent without div_done.
  assign timed_out = (state_q == WAIT) && !div_done &&
                     (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign locked    = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == WAIT && !div_done) wait_cnt_q <= wait_cnt_q + 1'b1;
      else                              wait_cnt_q <= '0;
      if (timed_out) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q && !reset;
`else
  assign timed_out   = 1'b0;
  assign locked      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // A locked (timed-out) arbiter stops granting: a granted channel could
  // never receive a response because no further div_start is issued.
  assign grant_en   = (state_q == IDLE) && !reset && !locked;
  assign grant_fire = grant_en && pick_any;

  assign sel_num = req_num[pick_idx*WIDTH +: WIDTH];
  assign sel_den = req_den[pick_idx*WIDTH +: WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (grant_fire)            state_d = ISSUE;
      ISSUE:                            state_d = WAIT;
      WAIT:  if (div_done || timed_out) state_d = RESP;
      RESP:                             state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Operand / owner / result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      owner_q <= '0;
      num_q   <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (grant_fire) begin
        owner_q <= pick_idx;
        num_q   <= sel_num;
        den_q   <= sel_den;
        ptr_q   <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state_q == WAIT) begin
        if (div_done) begin
          quo_q <= div_quotient;
          ovf_q <= div_overflow;
        end else if (timed_out) begin
          quo_q <= '1;
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // Outputs; combinational strobes are forced low while reset is asserted
  always_comb begin
    req_ready    = grant_en ? pick_grant : '0;
    div_start    = (state_q == ISSUE) && !reset;
    busy         = (state_q != IDLE) && !reset;
    rsp_valid    = '0;
    rsp_quotient = '0;
    rsp_overflow = 1'b0;
    if (state_q == RESP && !reset) begin
      rsp_valid    = NUM_REQ'(1) << owner_q;
      rsp_quotient = quo_q;
      rsp_overflow = ovf_q;
    end
  end

  assign div_numerator   = num_q;
  assign div_denominator = den_q;

endmodule

// File: tb/tb_rsi_div_arbiter.sv
// Self-checking bench for rsi_div_arbiter: directed scenarios plus a random
// phase, compared against a transaction-level reference model.
module tb_rsi_div_arbiter;

  localparam int N   = 4;
  localparam int W   = 55;
  localparam int TMO = 128;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_num, req_den;
  logic [N-1:0]     req_ready, rsp_valid;
  logic [W-1:0]     rsp_quotient;
  logic             rsp_overflow;
  logic             div_start;
  logic [W-1:0]     div_numerator, div_denominator;
  logic [W-1:0]     div_quotient;
  logic             div_done, div_overflow;
  logic             busy, err_timeout;

  rsi_div_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_num(req_num), .req_den(req_den),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_quotient(rsp_quotient), .rsp_overflow(rsp_overflow),
    .div_start(div_start), .div_numerator(div_numerator),
    .div_denominator(div_denominator), .div_quotient(div_quotient),
    .div_done(div_done), .div_overflow(div_overflow),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // staged stimulus (applied just after each rising edge)
  logic [N-1:0] nv;
  logic [W-1:0] nnum [N];
  logic [W-1:0] nden [N];
  bit           nreset;
  bit           hold_all, stray_en, no_done;
  int           fixed_lat;

  // divider model
  int           done_at;
  logic [W-1:0] dq;
  bit           dov;

  // reference model
  bit           inflight, started, locked_m, post_rst;
  int           own, ptr_m, free_from, rsp_due, start_due, wait_start;
  logic [W-1:0] gnum, gden, eq;
  bit           eov;

  // observations of DUT activity
  int           obs_grants [N];
  int           obs_rsp    [N];
  logic [W-1:0] last_q     [N];
  bit           last_ov    [N];
  int           obs_gq [$];
  int           t_grant, t_start, t_rsp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic observe();
    logic [N-1:0] er, ers;
    bit           eb, found;
    int           w, c;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin obs_grants[i]++; obs_gq.push_back(i); t_grant = cyc; end
      if (rsp_valid[i]) begin obs_rsp[i]++; last_q[i] = rsp_quotient; last_ov[i] = rsp_overflow; t_rsp = cyc; end
    end
    if (div_start) t_start = cyc;

    if (reset) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_div_start", div_start, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_timeout, 0);
      inflight = 0; started = 0; locked_m = 0; ptr_m = 0;
      rsp_due = -1; start_due = -1; free_from = cyc + 1; post_rst = 1;
      return;
    end
    if (post_rst) begin
      check("rst_div_num", div_numerator, 0);
      check("rst_div_den", div_denominator, 0);
      check("rst_rsp_q", rsp_quotient, 0);
      post_rst = 0;
    end

    eb = inflight;

    // grant: round robin from the model pointer over requests seen now
    er = '0; found = 0; w = 0;
    if (!inflight && cyc >= free_from && !locked_m) begin
      for (int k = 0; k < N; k++) begin
        c = (ptr_m + k) % N;
        if (!found && req_valid[c]) begin found = 1; w = c; end
      end
    end
    if (found) er[w] = 1'b1;
    if (!locked_m) check("req_ready", req_ready, er);
    if (found) begin
      own = w; gnum = nnum[w]; gden = nden[w];
      inflight = 1; started = 0; start_due = cyc + 1;
      ptr_m = (w + 1) % N;
      if (!hold_all) nv[w] = 1'b0;
    end

    check("div_start", div_start, (cyc == start_due));
    if (cyc == start_due) begin
      check("div_num", div_numerator, gnum);
      check("div_den", div_denominator, gden);
      started = 1; wait_start = cyc + 1; start_due = -1;
      if (!no_done) begin
        done_at = cyc + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(60, 1)));
        dov = (div_denominator == 0);
        dq  = dov ? '1 : div_numerator / div_denominator;
      end else begin
        rsp_due = cyc + 1 + TMO;
        eq = '1; eov = 1;
      end
    end

    if (div_done && inflight && started && cyc >= wait_start && rsp_due < 0) begin
      rsp_due = cyc + 1;
      eov = (gden == 0);
      eq  = eov ? '1 : gnum / gden;
    end
    if (done_at == cyc) done_at = -1;

    ers = '0;
    if (cyc == rsp_due) ers[own] = 1'b1;
    check("rsp_valid", rsp_valid, ers);
    if (cyc == rsp_due) begin
      check("rsp_quotient", rsp_quotient, eq);
      check("rsp_overflow", rsp_overflow, eov);
      inflight = 0; started = 0; rsp_due = -1; free_from = cyc + 1;
      if (no_done) locked_m = 1;
    end
    check("busy", busy, eb);
`ifdef DIV_TIMEOUT_EN
    check("err_timeout", err_timeout, locked_m);
`else
    check("err_timeout", err_timeout, 0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    reset     = nreset;
    req_valid = nv;
    for (int i = 0; i < N; i++) begin
      req_num[i*W +: W] = nnum[i];
      req_den[i*W +: W] = nden[i];
    end
    div_done     = (done_at == cyc);
    div_quotient = dq;
    div_overflow = dov;
    if (!div_done && stray_en && !inflight && done_at < 0 && $urandom_range(7) == 0) begin
      div_done     = 1'b1;
      div_quotient = rand_w();
      div_overflow = 1'($urandom_range(1));
    end
    @(negedge clk);
    observe();
    cyc++;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((inflight || nv != 0 || done_at >= 0) && n < limit) begin
      tick();
      n++;
    end
    check("drain_budget", (inflight || nv != 0 || done_at >= 0), 0);
  endtask

  task automatic do_reset();
    nreset = 1; tick(); tick();
    nreset = 0;
  endtask

  task automatic set_req(input int ch, input logic [W-1:0] a, input logic [W-1:0] b);
    nnum[ch] = a; nden[ch] = b; nv[ch] = 1'b1;
  endtask

  int saved0, saved1, ng;

  initial begin
    nv = '0; nreset = 1; hold_all = 0; stray_en = 0; no_done = 0; fixed_lat = 0;
    for (int i = 0; i < N; i++) begin
      nnum[i] = '0; nden[i] = '0; obs_grants[i] = 0; obs_rsp[i] = 0;
    end
    done_at = -1; dq = '0; dov = 0;
    inflight = 0; started = 0; locked_m = 0; post_rst = 0;
    own = 0; ptr_m = 0; free_from = 0; rsp_due = -1; start_due = -1; wait_start = 0;
    reset = 1; req_valid = '0; req_num = '0; req_den = '0;
    div_done = 0; div_quotient = '0; div_overflow = 0;
    do_reset();

    // single request, latency 55
    fixed_lat = 55;
    set_req(0, 1000, 250);
    drain(200);
    check("t1_quot", last_q[0], 4);
    check("t1_ovf", last_ov[0], 0);
    check("t1_start_lat", t_start - t_grant, 1);
    check("t1_rsp_lat", t_rsp - t_grant, 57);

    // all four at once from reset
    do_reset();
    obs_gq.delete();
    fixed_lat = 7;
    set_req(0, 400, 100); set_req(1, 900, 100);
    set_req(2, 1600, 100); set_req(3, 2500, 100);
    drain(200);
    check("t2_ngrants", obs_gq.size(), 4);
    for (int i = 0; i < N && i < obs_gq.size(); i++) check("t2_order", obs_gq[i], i);
    check("t2_q0", last_q[0], 4);
    check("t2_q1", last_q[1], 9);
    check("t2_q2", last_q[2], 16);
    check("t2_q3", last_q[3], 25);

    // zero denominator, done right after start
    fixed_lat = 1;
    set_req(2, 12345, 0);
    drain(50);
    check("t3_ovf", last_ov[2], 1);
    check("t3_quot", last_q[2], {W{1'b1}});
    tick();
    check("t3_busy_after", busy, 0);

    // reset in WAIT; stale done must be ignored; pointer restarts at 0
    do_reset();
    fixed_lat = 3;
    set_req(1, 49, 7);
    drain(50);
    fixed_lat = 20;
    saved0 = obs_rsp[0];
    set_req(0, 5000, 7);
    ng = 0;
    while (!started && ng < 50) begin tick(); ng++; end
    tick(); tick(); tick();
    nreset = 1; tick(); nreset = 0;
    ng = 0;
    while (done_at >= 0 && ng < 50) begin tick(); ng++; end
    tick(); tick();
    check("t4_no_rsp", obs_rsp[0], saved0);
    obs_gq.delete();
    fixed_lat = 4;
    set_req(1, 100, 10); set_req(3, 300, 10);
    drain(100);
    check("t4_first_grant", (obs_gq.size() > 0) ? obs_gq[0] : -1, 1);

    // withdrawn request is never granted
    saved0 = obs_grants[1]; saved1 = obs_rsp[1];
    fixed_lat = 30;
    set_req(0, 3000, 3);
    tick();
    set_req(1, 77, 11);
    repeat (5) tick();
    nv[1] = 1'b0;
    drain(100);
    check("t5_no_grant", obs_grants[1], saved0);
    check("t5_no_rsp", obs_rsp[1], saved1);

    // fairness with everyone continuously active
    do_reset();
    obs_gq.delete();
    fixed_lat = 2;
    hold_all = 1;
    for (int i = 0; i < N; i++) set_req(i, rand_w(), 1000 + i);
    ng = 0;
    while (obs_gq.size() < 12 && ng < 400) begin tick(); ng++; end
    nv = '0; hold_all = 0;
    drain(100);
    for (int i = 0; i < N; i++) begin
      ng = 0;
      for (int k = 0; k < 12 && k < obs_gq.size(); k++) if (obs_gq[k] == i) ng++;
      check("fair_count", ng, 3);
    end

    // random traffic
    fixed_lat = 0;
    stray_en = 1;
    for (int t = 0; t < 2500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!nv[i] && $urandom_range(3) == 0) begin
          case ($urandom_range(7))
            0:       set_req(i, rand_w(), '0);
            1, 2:    set_req(i, rand_w(), rand_w());
            default: set_req(i, rand_w(), W'($urandom_range(1000, 1)));
          endcase
        end else if (nv[i] && $urandom_range(15) == 0) begin
          nv[i] = 1'b0;
        end
      end
      tick();
    end
    nv = '0;
    stray_en = 0;
    drain(200);

`ifdef DIV_TIMEOUT_EN
    // watchdog: divider never finishes
    no_done = 1;
    saved0 = obs_rsp[2];
    set_req(2, 77, 7);
    ng = 0;
    while (obs_rsp[2] == saved0 && ng < 400) begin tick(); ng++; end
    check("tmo_rsp_lat", t_rsp - t_start, TMO + 1);
    check("tmo_quot", last_q[2], {W{1'b1}});
    check("tmo_ovf", last_ov[2], 1);
    set_req(0, 10, 2);
    repeat (20) tick();
    check("tmo_err_sticky", err_timeout, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rsi_div_arbiter.md
Name: rsi_div_arbiter

Overview:
Round-robin arbiter and sequencer that shares one iterative pipelined_divider between NUM_REQ RSI channels, one channel per symbol.
- Accepts a numerator/denominator pair from each requester.
- Issues exactly one division at a time and tracks the owning channel.
- Returns the quotient and overflow to that channel only.
- Sits between the per-symbol RSI FSMs and the single divider instance.

Parameters:
NUM_REQ, 4, number of requesting channels (2..16)
WIDTH, 55, operand/quotient width (PRICE_WIDTH 50 + clog2(14) + 1)
TIMEOUT_CYCLES, 128, watchdog limit in WAIT (used only with DIV_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
req_valid  in  NUM_REQ  per-channel request; held high with operands until its req_ready
req_num  in  NUM_REQ*WIDTH  flattened numerators, channel i at [i*WIDTH +: WIDTH]
req_den  in  NUM_REQ*WIDTH  flattened denominators, same packing
req_ready  out  NUM_REQ  one-hot, one-cycle grant; operands captured this cycle
rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe to owning channel
rsp_quotient  out  WIDTH  result, valid while any rsp_valid bit is high
rsp_overflow  out  1  divider overflow/timeout flag, valid with rsp_valid
div_start  out  1  one-cycle start pulse to divider
div_numerator  out  WIDTH  latched numerator, stable from div_start until div_done
div_denominator  out  WIDTH  latched denominator, same stability
div_quotient  in  WIDTH  divider result
div_done  in  1  divider completion pulse
div_overflow  in  1  divider overflow, sampled with div_done
busy  out  1  high in every state except IDLE
err_timeout  out  1  sticky watchdog error; tied 0 without DIV_TIMEOUT_EN

Behaviour:
- Reset:
  - All outputs 0. State IDLE, priority pointer 0, owner 0, latched operands 0.
  - Reset mid-operation discards the in-flight op; no rsp_valid is ever issued for it.
- State machine:
  - IDLE: if any req_valid, pick the winner by round-robin starting at the pointer. Pulse req_ready[winner], latch its operands and owner, set pointer = (winner+1) mod NUM_REQ, go to ISSUE.
  - ISSUE: div_start=1 for exactly one cycle, go to WAIT.
  - WAIT: on div_done, latch div_quotient/div_overflow, go to RESP. Otherwise stay.
  - RESP: rsp_valid[owner]=1 with the latched result for one cycle, go to IDLE.
- Latency: req seen in IDLE at cycle T gives req_ready at T, div_start at T+1, and rsp_valid at D+1, where D is the div_done cycle.
- Throughput: next grant no earlier than the cycle after RESP.
- div_done on the cycle right after div_start (divider zero-denominator path) is accepted normally.
- div_done outside WAIT is ignored.
- A requester may drop req_valid before it is granted; a withdrawn request is never granted.
- After req_ready a requester may change operands freely.
- A requester that reasserts req_valid while its own op is in flight is queued like any other request.
- Fairness: with all NUM_REQ requesters continuously active, each is granted exactly once per NUM_REQ grants.
- No arithmetic is performed by the arbiter; operands and results pass through unmodified (zero denominator is handled by the divider).

Optional Feature:
DIV_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT. If it reaches TIMEOUT_CYCLES without div_done, go to RESP with rsp_quotient all-ones and rsp_overflow=1.
  - err_timeout sets and stays high until reset.
  - The arbiter asserts no further div_start until reset.
- Undefined: no counter; WAIT holds indefinitely; err_timeout is constant 0.

Decomposition:
- Shared package rsi_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - DIV_WIDTH=55
  - RSI_NUM_CH=4
  - owner-index width function (clog2(NUM_REQ))
- One sub-module, rr_pick: combinational round-robin picker. Inputs: request vector and pointer. Outputs: one-hot grant and index.

Test Plan:
- Single request, ch0 num=1000 den=250, divider model latency 55 -> req_ready[0] at T, div_start at T+1, rsp_valid[0] with quotient 4 at done+1, overflow 0.
- All 4 channels request together from reset, each with distinct num (400, 900, 1600, 2500) and den=100 -> grant order 0,1,2,3; quotients 4, 9, 16, 25 each routed to the matching rsp_valid bit.
- ch2 den=0, divider returns done one cycle after start with overflow=1 and all-ones quotient -> rsp_valid[2], rsp_overflow=1, busy low the next cycle.
- Reset asserted while in WAIT, then div_done arrives -> no rsp_valid; outputs 0; next request to ch3 granted with pointer restarted at 0.
- ch1 withdraws req_valid before grant while ch0 is in flight -> ch1 never receives req_ready or rsp_valid.
- With DIV_TIMEOUT_EN and TIMEOUT_CYCLES=128, divider never asserts done -> rsp_valid[owner] 128 cycles after entering WAIT, quotient all-ones, overflow=1, err_timeout stays 1, no further div_start.
